// File: rtl/data_memory_responder.sv
// Memory-side responder for the GPU data memory channels: round-robin arbitration of
// per-channel read/write ports onto one single-port RAM, one op per cycle, 1-cycle latency.
module data_memory_responder #(
   parameter int NUM_CHANNELS = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 256
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]                 mem_write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

   localparam int SLOTS = 2 * NUM_CHANNELS;
   localparam int PTR_W = $clog2(SLOTS);
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   // BUSY collapses into the grant cycle, so a port is only ever IDLE or DONE.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DONE = 1'b1;

   logic [0:0]             state [SLOTS];
   logic [SLOTS-1:0]       slot_vld;
   logic [SLOTS-1:0]       cand;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       gnt_idx;
   logic [PTR_W-1:0]       rr_nxt;
   logic                   gnt_vld;
   logic                   gnt_wr;
   logic [PTR_W-2:0]       gnt_ch;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   rd_in_range;
   logic                   wr_in_range;
   logic [DATA_WIDTH-1:0]  ram [DEPTH];

   // Ring order interleaves read/write per channel: slot 2c = read c, slot 2c+1 = write c.
   always_comb begin
      slot_vld        = '0;
      cand            = '0;
      mem_read_ready  = '0;
      mem_write_ready = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         slot_vld[2*c]      = mem_read_valid[c];
         slot_vld[2*c+1]    = mem_write_valid[c];
         mem_read_ready[c]  = (state[2*c] == ST_DONE);
         mem_write_ready[c] = (state[2*c+1] == ST_DONE);
      end
      for (int s = 0; s < SLOTS; s++) begin
         cand[s] = (state[s] == ST_IDLE) && slot_vld[s];
      end
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!gnt_vld && cand[(int'(rr_ptr) + i) % SLOTS]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'((int'(rr_ptr) + i) % SLOTS);
         end
      end
   end

   assign gnt_wr      = gnt_idx[0];
   assign gnt_ch      = gnt_idx[PTR_W-1:1];
   assign rd_addr     = mem_read_address[gnt_ch];
   assign wr_addr     = mem_write_address[gnt_ch];
   assign wr_data     = mem_write_data[gnt_ch];
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
   assign rr_nxt      = (gnt_idx == PTR_W'(SLOTS - 1)) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < SLOTS; s++) begin
            state[s] <= ST_IDLE;
         end
         rr_ptr        <= '0;
         mem_read_data <= '0;
      end else begin
         for (int s = 0; s < SLOTS; s++) begin
            if (state[s] == ST_DONE && !slot_vld[s]) begin
               state[s] <= ST_IDLE;
            end
         end
         if (gnt_vld) begin
            state[gnt_idx] <= ST_DONE;
            rr_ptr         <= rr_nxt;
            if (!gnt_wr) begin
               mem_read_data[gnt_ch] <= rd_in_range ? ram[rd_addr] : '0;
            end
         end
      end
   end

   // RAM is never cleared; a grant that coincides with reset must not write.
   always_ff @(posedge clk) begin
      if (reset && gnt_vld && gnt_wr && wr_in_range) begin
         ram[wr_addr] <= wr_data;
      end
   end

endmodule
